// File: rtl/board_draw_scheduler_pkg.sv
// Shared encodings and default geometry for the board redraw scheduler.
// Slot index is row*4+col; job kind selects tile clear or digit glyph.
package board_draw_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_READ,
        ST_CLEAR,
        ST_WAIT_C,
        ST_GLYPH,
        ST_WAIT_G
    } state_t;

    localparam logic JOB_CLEAR = 1'b0;
    localparam logic JOB_GLYPH = 1'b1;

    localparam int BOARD_DIM  = 4;
    localparam int DEF_TILE_W = 30;
    localparam int DEF_TILE_H = 30;
    localparam int DEF_ORG_X  = 20;
    localparam int DEF_ORG_Y  = 0;

    function automatic logic [15:0] slot_bit(input logic [3:0] slot);
        return 16'h0001 << slot;
    endfunction

endpackage

// File: rtl/board_draw_scheduler_rr_pick16.sv
// Combinational round-robin priority encoder over a 16-bit mask.
// Returns the first set bit at index >= ptr, wrapping 15 -> 0; any=0 when mask is empty.
module rr_pick16 (
    input  logic [15:0] mask,
    input  logic [3:0]  ptr,
    output logic [3:0]  idx,
    output logic        any
);

    logic [3:0] cand;

    always_comb begin
        idx  = 4'd0;
        any  = 1'b0;
        cand = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!any && mask[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_draw_scheduler.sv
// Round-robin redraw scheduler for the 4x4 board: per dirty slot, a clear job then an optional glyph job.
// Mark-to-job_start latency is 4 cycles; each job waits for job_done, so the drawer paces the scheduler.
module board_draw_scheduler
    import board_draw_scheduler_pkg::*;
#(
    parameter int TILE_W = DEF_TILE_W,
    parameter int TILE_H = DEF_TILE_H,
    parameter int ORG_X  = DEF_ORG_X,
    parameter int ORG_Y  = DEF_ORG_Y
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       redraw_all,
    input  logic       mark_valid,
    input  logic [3:0] mark_slot,
    output logic [3:0] board_addr,
    input  logic [3:0] board_val,
    output logic       job_start,
    output logic       job_kind,
    output logic [3:0] job_glyph,
    output logic [7:0] job_x,
    output logic [6:0] job_y,
    input  logic       job_done,
    output logic       busy,
    output logic       frame_done
);

    state_t      state_q, state_d;
    logic [15:0] dirty_q, dirty_d, mark_vec, clr_vec;
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  cur_q, cur_d;
    logic [3:0]  cur_val_q, cur_val_d;
    logic        job_kind_q, job_kind_d;
    logic [3:0]  job_glyph_q, job_glyph_d;
    logic [7:0]  job_x_q, job_x_d;
    logic [6:0]  job_y_q, job_y_d;
    logic        frame_done_q, frame_done_d;
    logic        end_tile;
    logic [3:0]  pick_idx;
    logic        pick_any;

    rr_pick16 u_pick (
        .mask (dirty_q),
        .ptr  (rr_ptr_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        mark_vec = (redraw_all ? 16'hFFFF : 16'h0000)
                 | (mark_valid ? slot_bit(mark_slot) : 16'h0000);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_d        = cur_q;
        cur_val_d    = cur_val_q;
        job_kind_d   = job_kind_q;
        job_glyph_d  = job_glyph_q;
        job_x_d      = job_x_q;
        job_y_d      = job_y_q;
        frame_done_d = 1'b0;
        end_tile     = 1'b0;
        clr_vec      = 16'h0000;
        board_addr   = cur_q;
        job_start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|dirty_q) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (pick_any) begin
                    cur_d      = pick_idx;
                    board_addr = pick_idx;
                    clr_vec    = slot_bit(pick_idx);
                    state_d    = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                cur_val_d   = board_val;
                job_x_d     = 8'(ORG_X + (int'(cur_q) % BOARD_DIM) * TILE_W);
                job_y_d     = 7'(ORG_Y + (int'(cur_q) / BOARD_DIM) * TILE_H);
                job_kind_d  = JOB_CLEAR;
                job_glyph_d = 4'd0;
                state_d     = ST_CLEAR;
            end
            ST_CLEAR: begin
                job_start = 1'b1;
                state_d   = ST_WAIT_C;
            end
            ST_WAIT_C: begin
                if (job_done) begin
                    // Value 0 is the blank slot: clearing the rectangle is the whole redraw.
                    if (cur_val_q != 4'd0) begin
                        job_kind_d  = JOB_GLYPH;
                        job_glyph_d = cur_val_q;
                        state_d     = ST_GLYPH;
                    end else begin
                        end_tile = 1'b1;
                    end
                end
            end
            ST_GLYPH: begin
                job_start = 1'b1;
                state_d   = ST_WAIT_G;
            end
            ST_WAIT_G: begin
                if (job_done) end_tile = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Marks are ORed in after the clear so a same-cycle re-mark survives.
        dirty_d = (dirty_q & ~clr_vec) | mark_vec;

        if (end_tile) begin
            rr_ptr_d = cur_q + 4'd1;
            if (|dirty_d) begin
                state_d = ST_SCAN;
            end else begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dirty_q      <= 16'h0000;
            rr_ptr_q     <= 4'd0;
            cur_q        <= 4'd0;
            cur_val_q    <= 4'd0;
            job_kind_q   <= JOB_CLEAR;
            job_glyph_q  <= 4'd0;
            job_x_q      <= 8'd0;
            job_y_q      <= 7'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dirty_q      <= dirty_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_q        <= cur_d;
            cur_val_q    <= cur_val_d;
            job_kind_q   <= job_kind_d;
            job_glyph_q  <= job_glyph_d;
            job_x_q      <= job_x_d;
            job_y_q      <= job_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign job_kind   = job_kind_q;
    assign job_glyph  = job_glyph_q;
    assign job_x      = job_x_q;
    assign job_y      = job_y_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_board_draw_scheduler.sv
// Directed bench for board_draw_scheduler: board RAM and drawer models, a job-level scoreboard,
// and literal checks on latency, geometry, ordering and reset behaviour.
module tb_board_draw_scheduler;

    logic       clk;
    logic       reset;
    logic       redraw_all;
    logic       mark_valid;
    logic [3:0] mark_slot;
    logic [3:0] board_addr;
    logic [3:0] board_val;
    logic       job_start;
    logic       job_kind;
    logic [3:0] job_glyph;
    logic [7:0] job_x;
    logic [6:0] job_y;
    logic       job_done;
    logic       busy;
    logic       frame_done;

    board_draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .redraw_all (redraw_all),
        .mark_valid (mark_valid),
        .mark_slot  (mark_slot),
        .board_addr (board_addr),
        .board_val  (board_val),
        .job_start  (job_start),
        .job_kind   (job_kind),
        .job_glyph  (job_glyph),
        .job_x      (job_x),
        .job_y      (job_y),
        .job_done   (job_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] board_mem [16];
    always @(posedge clk) board_val <= board_mem[board_addr];

    typedef struct packed {
        logic       kind;
        logic [3:0] glyph;
        logic [7:0] x;
        logic [6:0] y;
    } job_t;

    job_t exp_q[$];
    job_t snap;
    int   errors;
    int   checks;
    int   m_ptr;
    int   drv_delay;
    int   drv_cnt;
    int   fd_cnt;
    int   start_cnt;
    logic prev_start;
    logic outstanding;
    logic done_flag;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Expected jobs for one slot, straight from the board geometry and tile value.
    task automatic expect_slot(input int s);
        job_t j;
        j.kind  = 1'b0;
        j.glyph = 4'd0;
        j.x     = 8'(20 + 30 * (s % 4));
        j.y     = 7'(30 * (s / 4));
        exp_q.push_back(j);
        if (board_mem[s] != 4'd0) begin
            j.kind  = 1'b1;
            j.glyph = board_mem[s];
            exp_q.push_back(j);
        end
    endtask

    // A static dirty set is served in index order starting at the pointer, wrapping.
    task automatic expect_pass(input logic [15:0] mask);
        int s;
        int last;
        last = m_ptr;
        for (int n = 0; n < 16; n++) begin
            s = (m_ptr + n) % 16;
            if (mask[s]) begin
                expect_slot(s);
                last = s;
            end
        end
        m_ptr = (last + 1) % 16;
    endtask

    // One clock: inputs set beforehand are sampled at the edge, then outputs are checked.
    task automatic tick();
        job_t e;
        @(posedge clk);
        #2;
        mark_valid = 1'b0;
        redraw_all = 1'b0;
        job_done   = 1'b0;
        if (reset) begin
            prev_start  = 1'b0;
            outstanding = 1'b0;
            done_flag   = 1'b0;
            drv_cnt     = 0;
        end else begin
            if (job_start) begin
                chk("no_back_to_back_start", int'(prev_start), 0);
                chk("start_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("job_kind", int'(job_kind), int'(e.kind));
                    chk("job_glyph", int'(job_glyph), int'(e.glyph));
                    chk("job_x", int'(job_x), int'(e.x));
                    chk("job_y", int'(job_y), int'(e.y));
                end
                snap        = {job_kind, job_glyph, job_x, job_y};
                outstanding = 1'b1;
                done_flag   = 1'b0;
                start_cnt++;
                drv_cnt     = drv_delay;
            end else if (outstanding) begin
                chk("job_fields_held", int'({job_kind, job_glyph, job_x, job_y}), int'(snap));
                if (done_flag) begin
                    outstanding = 1'b0;
                    done_flag   = 1'b0;
                end else begin
                    chk("busy_during_job", int'(busy), 1);
                end
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_end_jobs_left", exp_q.size(), 0);
                chk("frame_end_busy", int'(busy), 0);
            end
            prev_start = job_start;
            if (!job_start && drv_cnt > 0) begin
                drv_cnt--;
                if (drv_cnt == 0) begin
                    job_done  = 1'b1;
                    done_flag = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_start(input int base, output int n);
        n = 0;
        while (start_cnt == base && n < 50) begin
            tick();
            n++;
        end
        chk("start_seen", int'(start_cnt != base), 1);
    endtask

    task automatic wait_frame(input int base, input int budget);
        int n;
        n = 0;
        while (fd_cnt == base && n < budget) begin
            tick();
            n++;
        end
        chk("frame_done_seen", int'(fd_cnt != base), 1);
        repeat (3) tick();
    endtask

    initial begin
        int fd0;
        int s0;
        int lat;
        int busy_seen;

        errors = 0; checks = 0; m_ptr = 0; drv_delay = 4; drv_cnt = 0;
        fd_cnt = 0; start_cnt = 0; prev_start = 1'b0; outstanding = 1'b0; done_flag = 1'b0;
        reset = 1'b1; redraw_all = 1'b0; mark_valid = 1'b0; mark_slot = 4'd0; job_done = 1'b0;
        for (int s = 0; s < 16; s++) board_mem[s] = (s == 15) ? 4'd0 : 4'(s + 1);
        board_mem[5] = 4'd9;
        board_mem[8] = 4'd6;

        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_job_start", int'(job_start), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_job_fields", int'({job_kind, job_glyph, job_x, job_y, board_addr}), 0);
        reset = 1'b0;
        tick();

        // Slot 5 holding 9: clear at (50,30) four cycles after the mark, then glyph 9.
        fd0 = fd_cnt; s0 = start_cnt;
        expect_pass(16'h0020);
        chk("model_slot5_x", int'(exp_q[0].x), 50);
        chk("model_slot5_y", int'(exp_q[0].y), 30);
        chk("model_slot5_glyph", int'(exp_q[1].glyph), 9);
        mark_slot = 4'd5; mark_valid = 1'b1;
        wait_start(s0, lat);
        chk("mark_to_start_latency", lat, 4);
        chk("first_job_kind", int'(job_kind), 0);
        chk("first_job_x", int'(job_x), 50);
        chk("first_job_y", int'(job_y), 30);
        wait_frame(fd0, 100);
        chk("slot5_frames", fd_cnt - fd0, 1);
        chk("slot5_jobs", start_cnt - s0, 2);
        chk("slot5_idle_after", int'(busy), 0);

        // Pointer now 6: slots 2 and 10 dirty, slot 10 goes first.
        fd0 = fd_cnt; s0 = start_cnt;
        expect_pass(16'h0404);
        chk("model_rr_first_y", int'(exp_q[0].y), 60);
        mark_slot = 4'd2; mark_valid = 1'b1;
        tick();
        mark_slot = 4'd10; mark_valid = 1'b1;
        wait_start(s0, lat);
        chk("rr_first_job_y", int'(job_y), 60);
        wait_frame(fd0, 100);
        chk("rr_frames", fd_cnt - fd0, 1);
        chk("rr_jobs", start_cnt - s0, 4);

        // Blank slot 15: a single clear job at (110,90).
        fd0 = fd_cnt; s0 = start_cnt;
        expect_pass(16'h8000);
        chk("model_blank_jobs", exp_q.size(), 1);
        mark_slot = 4'd15; mark_valid = 1'b1;
        wait_start(s0, lat);
        chk("blank_job_x", int'(job_x), 110);
        chk("blank_job_y", int'(job_y), 90);
        wait_frame(fd0, 100);
        chk("blank_frames", fd_cnt - fd0, 1);
        chk("blank_jobs", start_cnt - s0, 1);

        // Full redraw with a 3-cycle drawer: 16 clears + 15 glyphs, one frame_done.
        drv_delay = 3;
        fd0 = fd_cnt; s0 = start_cnt;
        expect_pass(16'hFFFF);
        chk("model_full_jobs", exp_q.size(), 31);
        redraw_all = 1'b1;
        wait_frame(fd0, 1000);
        chk("full_frames", fd_cnt - fd0, 1);
        chk("full_jobs", start_cnt - s0, 31);

        // Re-mark slot 3 while its glyph is being drawn: drawn again in the same frame.
        fd0 = fd_cnt; s0 = start_cnt;
        expect_slot(3);
        expect_slot(3);
        m_ptr = 4;
        mark_slot = 4'd3; mark_valid = 1'b1;
        wait_start(s0, lat);
        wait_start(s0 + 1, lat);
        chk("remark_glyph_phase", int'(job_kind), 1);
        tick();
        chk("remark_busy_wait_g", int'(busy), 1);
        mark_slot = 4'd3; mark_valid = 1'b1;
        wait_frame(fd0, 200);
        chk("remark_frames", fd_cnt - fd0, 1);
        chk("remark_jobs", start_cnt - s0, 4);

        // Mark slot 3 in the very cycle it is being scanned: the bit stays set.
        fd0 = fd_cnt; s0 = start_cnt;
        expect_slot(3);
        expect_slot(3);
        mark_slot = 4'd3; mark_valid = 1'b1;
        tick();
        tick();
        chk("scan_board_addr", int'(board_addr), 3);
        mark_slot = 4'd3; mark_valid = 1'b1;
        wait_frame(fd0, 200);
        chk("samecycle_frames", fd_cnt - fd0, 1);
        chk("samecycle_jobs", start_cnt - s0, 4);

        // Reset during WAIT_C with another slot pending, then a stray job_done in IDLE.
        drv_delay = 6;
        s0 = start_cnt;
        expect_slot(0);
        mark_slot = 4'd0; mark_valid = 1'b1;
        wait_start(s0, lat);
        mark_slot = 4'd4; mark_valid = 1'b1;
        tick();
        chk("wait_c_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        chk("midjob_reset_busy", int'(busy), 0);
        chk("midjob_reset_start", int'(job_start), 0);
        chk("midjob_reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        exp_q.delete();
        s0 = start_cnt; fd0 = fd_cnt;
        job_done = 1'b1;
        busy_seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (busy) busy_seen++;
        end
        chk("post_reset_busy_cycles", busy_seen, 0);
        chk("post_reset_starts", start_cnt - s0, 0);
        chk("post_reset_frames", fd_cnt - fd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_draw_scheduler.md
Name: board_draw_scheduler

Overview:
- Sequences redraws of the 4x4 sliding-puzzle board onto the 160x120 frame buffer.
- Holds a per-slot dirty mask set by game logic. Serves dirty slots round-robin.
- For each served slot, issues a tile-clear job and then a digit-glyph job to the shared stroke/glyph drawer, using a start/done handshake.
- Sits between the move/board logic and the glyph drawer plus VGA plot mux. It is the only master of the drawer.

Parameters:
- TILE_W, 30, tile pitch in x (pixels)
- TILE_H, 30, tile pitch in y (pixels)
- ORG_X, 20, board origin x
- ORG_Y, 0, board origin y

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- redraw_all  in  1  pulse; marks all 16 slots dirty
- mark_valid  in  1  pulse; marks slot mark_slot dirty
- mark_slot  in  4  slot index, row*4+col
- board_addr  out  4  slot index presented to board RAM
- board_val  in  4  tile value at board_addr, valid 1 cycle after address (registered read)
- job_start  out  1  one-cycle pulse launching a drawer job
- job_kind  out  1  0 = clear tile rectangle, 1 = draw glyph
- job_glyph  out  4  glyph code 1..15 (0 when job_kind=0)
- job_x  out  8  tile origin x
- job_y  out  7  tile origin y
- job_done  in  1  pulse from drawer when the current job has finished
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when the dirty mask drains to empty

Behaviour:
- Reset values: state=IDLE, dirty=16'h0000, rr_ptr=0; all outputs 0. Reset mid-job abandons the job; the drawer is reset by the same signal.
- Dirty mask:
  - redraw_all sets all bits.
  - mark_valid sets bit mark_slot.
  - Both may occur in one cycle; the result is the OR.
  - A mark and the scheduler's clear of the same bit in one cycle: the mark wins (bit stays 1).
- FSM states: IDLE, SCAN, READ, CLEAR, WAIT_C, GLYPH, WAIT_G.
  - IDLE: move to SCAN when dirty!=0 (evaluated on the registered mask).
  - SCAN (1 cycle): round-robin priority encode. Pick the first set bit at index >= rr_ptr, wrapping 15->0. Latch it as cur. Drive board_addr=cur. Clear dirty[cur]. Go to READ.
  - READ (1 cycle): latch board_val as cur_val. Compute job_x = ORG_X + col*TILE_W and job_y = ORG_Y + row*TILE_H (8-bit/7-bit, no overflow with the defaults). Go to CLEAR.
  - CLEAR: pulse job_start with job_kind=0. Go to WAIT_C.
  - WAIT_C: wait for job_done. Then go to GLYPH if cur_val!=0; otherwise end the tile. Value 0 is the blank slot and is clear-only.
  - GLYPH: pulse job_start with job_kind=1 and job_glyph=cur_val. Go to WAIT_G.
  - WAIT_G: on job_done, end the tile.
- End of tile:
  - rr_ptr = cur+1 (mod 16).
  - If the dirty mask, including same-cycle marks, is nonzero, go to SCAN.
  - Otherwise pulse frame_done and go to IDLE.
- job_x, job_y, job_kind and job_glyph are registered and held stable from the start pulse until the cycle after job_done.
- job_done outside WAIT_C/WAIT_G is ignored.
- A slot marked while it is being drawn is redrawn on a later pass, because its bit was cleared at SCAN.
- Latency: a mark in IDLE produces job_start 4 cycles later (IDLE->SCAN->READ->CLEAR, pulse visible in CLEAR).
- No back-to-back job_start: at least one WAIT cycle between jobs.

Decomposition:
- Shared package holds:
  - the state encoding
  - constants JOB_CLEAR=0 and JOB_GLYPH=1
  - BOARD_DIM=4
  - the default tile geometry
- One natural sub-module: rr_pick16 (combinational 16-bit round-robin priority encoder; inputs mask and ptr; outputs idx and any).

Test Plan:
- Reset, then mark slot 5 with board_val=9 -> job_start at cycle +4 with kind=0, x=50, y=30. After job_done, a second start with kind=1, glyph=9. After that job_done, frame_done pulses and busy falls.
- Mark slot 15 with board_val=0 -> exactly one job (kind=0, x=110, y=90), then frame_done.
- redraw_all, drawer returning done 3 cycles after each start -> 31 jobs (15 glyphs + 1 blank) in slot order 0..15, single frame_done at the end.
- rr_ptr=6 with slots 2 and 10 dirty -> slot 10 is served first, then slot 2.
- Re-mark slot 3 during its WAIT_G -> slot 3 is drawn a second time. Also assert mark and SCAN-clear of slot 3 in the same cycle -> bit remains set.
- Assert reset during WAIT_C -> next cycle state IDLE, dirty=0, job_start=0, busy=0. Spurious job_done in IDLE produces no activity.
